accelshark_psg_regbank: RTL and testbench
=========================================

ACCELSHARK_PSG_REGBANK -- requirements
Module: accelshark_psg_regbank

Interface
REQ-001 SHALL have parameter VOICES, default 4, legal range 1..16: number of voice register sets.
REQ-002 SHALL have parameter PITCH_W, default 8, legal range 8..12: pitch width; pitch is split across two bytes when PITCH_W > 8.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1: clock enable; when low, no state changes except reset.
REQ-006 SHALL have port strobe  input  1: write one nybble this cycle.
REQ-007 SHALL have port address  input  1: 1 = nybble is address, 0 = nybble is data.
REQ-008 SHALL have port data_high  input  1: 1 = high nybble, 0 = low nybble.
REQ-009 SHALL have port da  input  4: nybble value.
REQ-010 SHALL have port frame_tick  input  1: single-cycle frame boundary pulse from the sequencer.
REQ-011 SHALL have port voice_enable  output  VOICES: active per-voice enable.
REQ-012 SHALL have port voice_octave  output  3*VOICES: active octaves; voice v at bits [3v+2:3v].
REQ-013 SHALL have port voice_pitch  output  PITCH_W*VOICES: active pitches; voice v at bits [PITCH_W*v +: PITCH_W].
REQ-014 SHALL have port voice_volume  output  4*VOICES: active volumes.
REQ-015 SHALL have port commit_pending  output  1: a commit is armed and waiting for frame_tick.
REQ-016 SHALL have port rd_nybble  output  4: readback nybble (REQ-034).

Function
REQ-017 A write SHALL occur only when ena & strobe are both high; it is called a "strobe" below.
REQ-018 An address strobe SHALL load da into addr[7:4] if data_high, else addr[3:0].
REQ-019 A data strobe with data_high=1 SHALL load da into hold[7:4] only; no register write.
REQ-020 A data strobe with data_high=0 SHALL write {hold[7:4], da} to the shadow register at addr on that edge.
REQ-021 Register map: 0x00 CTRL (bit0 AUTOINC, bit1 IMMEDIATE); 0x01 COMMIT; 0x02/0x03 voice_enable bits [7:0]/[15:8]; 0x10+4v pitch[7:0]; 0x11+4v {octave[2:0] at [6:4], pitch[PITCH_W-1:8] at [3:0]}; 0x12+4v volume[3:0]; 0x13+4v reserved.
REQ-022 Writes to unmapped addresses, reserved slots, voices >= VOICES, or unused bits SHALL be ignored without side effects.
REQ-023 When AUTOINC=1, every byte write (REQ-020) SHALL increment addr by 1 on the same edge, wrapping 0xFF -> 0x00; an address strobe in the same cycle cannot occur (single strobe bus).
REQ-024 Writing COMMIT with bit0=1 SHALL set commit_pending on that edge; bit0=0 SHALL clear it (cancel).
REQ-025 On a cycle with ena & frame_tick & commit_pending, all active registers SHALL load shadow values and commit_pending SHALL clear; outputs change one cycle after that edge's inputs.
REQ-026 If a COMMIT write and frame_tick coincide, pending SHALL be set and the copy SHALL wait for the next frame_tick.
REQ-027 If a shadow byte write and a commit copy coincide, the copy SHALL use the pre-write shadow value; the new byte waits for the next commit.
REQ-028 When IMMEDIATE=1, byte writes SHALL update shadow and active copies on the same edge; COMMIT still operates.
REQ-029 CTRL and COMMIT SHALL not be double-buffered.
REQ-030 frame_tick without pending SHALL have no effect.

Reset
REQ-031 With rst high on a clock edge, addr, hold, CTRL, commit_pending, all shadow and active registers, and rd_nybble SHALL become 0; rst overrides ena and all strobes.
REQ-032 Reset asserted mid-sequence (after high nybble, before low) SHALL discard the partial byte.

Configuration
REQ-033 Macro PSG_READBACK_EN SHALL select readback support.
REQ-034 With PSG_READBACK_EN defined, rd_nybble SHALL register, one cycle after each clock with ena high, the shadow byte at addr (CTRL/COMMIT bit0 readable; unmapped reads 0), nybble selected by data_high.
REQ-035 Without PSG_READBACK_EN, rd_nybble SHALL be tied to 0 and no readback mux is built.

Verification
REQ-036 Reset, then addr 0x10, data 0xA then 0x5 -> shadow pitch0=0xA5, voice_pitch unchanged 0; COMMIT=0x01, frame_tick -> voice_pitch[7:0]=0xA5 next cycle, commit_pending 1->0.
REQ-037 CTRL=0x01, addr 0x10, write bytes 0x11,0x32,0x0F -> after commit voice0 pitch 0x211 (PITCH_W=10 with 0x32 -> octave 3, pitch hi 2) volume 0xF; addr ends 0x13.
REQ-038 COMMIT write and frame_tick same cycle -> no copy; copy on following frame_tick only.
REQ-039 VOICES=4: write 0x20 (voice 4 pitch) and 0x04 -> no change to any output; CTRL=0x02, write addr 0x16 data 0x07 -> voice1 volume 7 next cycle without frame_tick.
REQ-040 ena=0 with strobes and frame_tick -> no state change; rst high after high nybble 0xC then low nybble 0x3 -> register receives 0x03.
REQ-041 With PSG_READBACK_EN: addr 0x10 holding 0xA5, data_high=1 -> rd_nybble 0xA after one cycle; without macro rd_nybble stays 0.

Source files
------------

// File: rtl/accelshark_psg_regbank.sv
// PSG voice register bank: nybble-serial writes into shadow regs, frame-synced commit.
// Define PSG_READBACK_EN to build the shadow readback path on rd_nybble.
module accelshark_psg_regbank #(
  parameter int VOICES  = 4,
  parameter int PITCH_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        strobe,
  input  logic                        address,
  input  logic                        data_high,
  input  logic [3:0]                  da,
  input  logic                        frame_tick,
  output logic [VOICES-1:0]           voice_enable,
  output logic [3*VOICES-1:0]         voice_octave,
  output logic [PITCH_W*VOICES-1:0]   voice_pitch,
  output logic [4*VOICES-1:0]         voice_volume,
  output logic                        commit_pending,
  output logic [3:0]                  rd_nybble
);

  localparam logic [7:0] VEND = 8'(16 + 4 * VOICES);

  logic [7:0]         addr_q, addr_d;
  logic [3:0]         hold_q, hold_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               pend_q, pend_d;
  logic [VOICES-1:0]  sh_en_q, sh_en_d;
  logic [VOICES-1:0]  ac_en_q, ac_en_d;
  logic [2:0]         sh_oct_q [VOICES];
  logic [2:0]         sh_oct_d [VOICES];
  logic [2:0]         ac_oct_q [VOICES];
  logic [2:0]         ac_oct_d [VOICES];
  logic [PITCH_W-1:0] sh_pit_q [VOICES];
  logic [PITCH_W-1:0] sh_pit_d [VOICES];
  logic [PITCH_W-1:0] ac_pit_q [VOICES];
  logic [PITCH_W-1:0] ac_pit_d [VOICES];
  logic [3:0]         sh_vol_q [VOICES];
  logic [3:0]         sh_vol_d [VOICES];
  logic [3:0]         ac_vol_q [VOICES];
  logic [3:0]         ac_vol_d [VOICES];

  logic [7:0] wb;
  logic [7:0] off;
  logic       awr, hwr, wr, cwr, fire, vsel;

  always_comb begin
    wb   = {hold_q, da};
    awr  = ena & strobe & address;
    hwr  = ena & strobe & ~address & data_high;
    wr   = ena & strobe & ~address & ~data_high;
    cwr  = wr & (addr_q == 8'h01);
    // a COMMIT write on the tick edge re-arms; the copy waits a frame
    fire = ena & frame_tick & pend_q & ~cwr;
    off  = addr_q - 8'h10;
    vsel = (addr_q >= 8'h10) && (addr_q < VEND);
  end

  always_comb begin
    addr_d  = addr_q;
    hold_d  = hold_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    sh_en_d = sh_en_q;
    ac_en_d = fire ? sh_en_q : ac_en_q;
    for (int v = 0; v < VOICES; v++) begin
      sh_oct_d[v] = sh_oct_q[v];
      sh_pit_d[v] = sh_pit_q[v];
      sh_vol_d[v] = sh_vol_q[v];
      ac_oct_d[v] = fire ? sh_oct_q[v] : ac_oct_q[v];
      ac_pit_d[v] = fire ? sh_pit_q[v] : ac_pit_q[v];
      ac_vol_d[v] = fire ? sh_vol_q[v] : ac_vol_q[v];
    end
    if (awr) begin
      if (data_high) addr_d[7:4] = da;
      else           addr_d[3:0] = da;
    end
    if (hwr) hold_d = da;
    if (fire) pend_d = 1'b0;
    if (wr) begin
      if (ctrl_q[0]) addr_d = addr_q + 8'h01;
      if (addr_q == 8'h00) ctrl_d = wb[1:0];
      if (cwr) pend_d = wb[0];
      for (int i = 0; i < VOICES; i++) begin
        if (addr_q == ((i < 8) ? 8'h02 : 8'h03)) begin
          sh_en_d[i] = wb[3'(i)];
          if (ctrl_q[1]) ac_en_d[i] = wb[3'(i)];
        end
      end
      for (int v = 0; v < VOICES; v++) begin
        if (vsel && off[5:2] == 4'(v)) begin
          unique case (off[1:0])
            2'd0: begin
              sh_pit_d[v][7:0] = wb;
              if (ctrl_q[1]) ac_pit_d[v][7:0] = wb;
            end
            2'd1: begin
              sh_oct_d[v] = wb[6:4];
              if (ctrl_q[1]) ac_oct_d[v] = wb[6:4];
              for (int k = 8; k < PITCH_W; k++) begin
                sh_pit_d[v][k] = wb[2'(k)];
                if (ctrl_q[1]) ac_pit_d[v][k] = wb[2'(k)];
              end
            end
            2'd2: begin
              sh_vol_d[v] = wb[3:0];
              if (ctrl_q[1]) ac_vol_d[v] = wb[3:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      hold_q  <= '0;
      ctrl_q  <= '0;
      pend_q  <= 1'b0;
      sh_en_q <= '0;
      ac_en_q <= '0;
      for (int v = 0; v < VOICES; v++) begin
        sh_oct_q[v] <= '0;
        sh_pit_q[v] <= '0;
        sh_vol_q[v] <= '0;
        ac_oct_q[v] <= '0;
        ac_pit_q[v] <= '0;
        ac_vol_q[v] <= '0;
      end
    end else begin
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      sh_en_q <= sh_en_d;
      ac_en_q <= ac_en_d;
      for (int v = 0; v < VOICES; v++) begin
        sh_oct_q[v] <= sh_oct_d[v];
        sh_pit_q[v] <= sh_pit_d[v];
        sh_vol_q[v] <= sh_vol_d[v];
        ac_oct_q[v] <= ac_oct_d[v];
        ac_pit_q[v] <= ac_pit_d[v];
        ac_vol_q[v] <= ac_vol_d[v];
      end
    end
  end

  always_comb begin
    voice_enable = ac_en_q;
    voice_octave = '0;
    voice_pitch  = '0;
    voice_volume = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_octave[3*v +: 3]             = ac_oct_q[v];
      voice_pitch[PITCH_W*v +: PITCH_W]  = ac_pit_q[v];
      voice_volume[4*v +: 4]             = ac_vol_q[v];
    end
  end

  assign commit_pending = pend_q;

`ifdef PSG_READBACK_EN
  logic [7:0] rb;
  logic [3:0] rd_q, rd_d;

  always_comb begin
    rb = 8'h00;
    if (addr_q == 8'h00) rb = {6'b0, ctrl_q};
    if (addr_q == 8'h01) rb = {7'b0, pend_q};
    for (int i = 0; i < VOICES; i++) begin
      if (addr_q == ((i < 8) ? 8'h02 : 8'h03)) rb[3'(i)] = sh_en_q[i];
    end
    for (int v = 0; v < VOICES; v++) begin
      if (vsel && off[5:2] == 4'(v)) begin
        unique case (off[1:0])
          2'd0: rb = sh_pit_q[v][7:0];
          2'd1: begin
            rb[6:4] = sh_oct_q[v];
            for (int k = 8; k < PITCH_W; k++) rb[2'(k)] = sh_pit_q[v][k];
          end
          2'd2: rb[3:0] = sh_vol_q[v];
          default: ;
        endcase
      end
    end
    rd_d = rd_q;
    if (ena) rd_d = data_high ? rb[7:4] : rb[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_nybble = rd_q;
`else
  assign rd_nybble = 4'h0;
`endif

endmodule

// File: tb/tb_accelshark_psg_regbank.sv
// Scoreboard bench: byte-map reference model feeds a queue checked per cycle.
`timescale 1ns/1ps
module tb_accelshark_psg_regbank;
  localparam int V  = 4;
  localparam int PW = 10;

  logic clk = 0, rst = 0, ena = 0, strobe = 0;
  logic address = 0, data_high = 0, frame_tick = 0;
  logic [3:0] da = 0;
  logic [V-1:0]    voice_enable;
  logic [3*V-1:0]  voice_octave;
  logic [PW*V-1:0] voice_pitch;
  logic [4*V-1:0]  voice_volume;
  logic            commit_pending;
  logic [3:0]      rd_nybble;

  accelshark_psg_regbank #(.VOICES(V), .PITCH_W(PW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .strobe(strobe),
    .address(address), .data_high(data_high), .da(da),
    .frame_tick(frame_tick), .voice_enable(voice_enable),
    .voice_octave(voice_octave), .voice_pitch(voice_pitch),
    .voice_volume(voice_volume), .commit_pending(commit_pending),
    .rd_nybble(rd_nybble)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [V-1:0]    en;
    logic [3*V-1:0]  oct;
    logic [PW*V-1:0] pit;
    logic [4*V-1:0]  vol;
    logic            pend;
    logic [3:0]      rd;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  bit [7:0] m_sh [256];
  bit [7:0] m_ac [256];
  bit [7:0] m_addr;
  bit [3:0] m_hold;
  bit [1:0] m_ctrl;
  bit       m_pend;
  bit [3:0] m_rd;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic bit [7:0] mask(input bit [7:0] a);
    if (a == 8'h02) return (V >= 8) ? 8'hFF : 8'((1 << V) - 1);
    if (a == 8'h03) return (V > 8) ? 8'((1 << (V - 8)) - 1) : 8'h00;
    if (a >= 8'h10 && int'(a) < 16 + 4 * V) begin
      case (a[1:0])
        2'd0: return 8'hFF;
        2'd1: return 8'h70 | 8'((1 << (PW - 8)) - 1);
        2'd2: return 8'h0F;
        default: return 8'h00;
      endcase
    end
    return 8'h00;
  endfunction

  task automatic model_step(input bit r, e, s, ad, dh, input bit [3:0] d, input bit t);
    bit [7:0] old_sh [256];
    bit [7:0] oaddr, b, rb;
    bit [1:0] octrl;
    bit       opend, wr, fire;
    if (r) begin
      for (int a = 0; a < 256; a++) begin m_sh[a] = 0; m_ac[a] = 0; end
      m_addr = 0; m_hold = 0; m_ctrl = 0; m_pend = 0; m_rd = 0;
      return;
    end
    if (!e) return;
    old_sh = m_sh; oaddr = m_addr; octrl = m_ctrl; opend = m_pend;
    wr = s && !ad && !dh;
    b = {m_hold, d};
    fire = t && opend && !(wr && oaddr == 8'h01);
`ifdef PSG_READBACK_EN
    rb = (oaddr == 0) ? {6'b0, octrl} : (oaddr == 1) ? {7'b0, opend} : old_sh[oaddr];
    m_rd = dh ? rb[7:4] : rb[3:0];
`else
    rb = 8'h00;
    m_rd = rb[3:0];
`endif
    if (fire) begin
      for (int a = 2; a < 256; a++) m_ac[a] = old_sh[a];
      m_pend = 0;
    end
    if (s && ad) begin
      if (dh) m_addr[7:4] = d;
      else    m_addr[3:0] = d;
    end
    if (s && !ad && dh) m_hold = d;
    if (wr) begin
      if (oaddr == 0) m_ctrl = b[1:0];
      else if (oaddr == 1) m_pend = b[0];
      else begin
        m_sh[oaddr] = b & mask(oaddr);
        if (octrl[1]) m_ac[oaddr] = b & mask(oaddr);
      end
      if (octrl[0]) m_addr = oaddr + 8'h01;
    end
  endtask

  function automatic exp_t mk();
    exp_t x;
    bit [11:0] p;
    x = '0;
    for (int v = 0; v < V; v++) begin
      x.en[v] = (v < 8) ? m_ac[2][3'(v)] : m_ac[3][3'(v)];
      p = {m_ac[17 + 4*v][3:0], m_ac[16 + 4*v]};
      x.pit[PW*v +: PW] = p[PW-1:0];
      x.oct[3*v +: 3]   = m_ac[17 + 4*v][6:4];
      x.vol[4*v +: 4]   = m_ac[18 + 4*v][3:0];
    end
    x.pend = m_pend;
    x.rd   = m_rd;
    return x;
  endfunction

  task automatic cyc(input bit r, e, s, ad, dh, input bit [3:0] d, input bit t);
    @(negedge clk);
    rst = r; ena = e; strobe = s; address = ad;
    data_high = dh; da = d; frame_tick = t;
    @(posedge clk);
    #1;
    model_step(r, e, s, ad, dh, d, t);
    sbq.push_back(mk());
  endtask

  task automatic set_addr(input bit [7:0] a);
    cyc(0, 1, 1, 1, 1, a[7:4], 0);
    cyc(0, 1, 1, 1, 0, a[3:0], 0);
  endtask

  task automatic wr_byte(input bit [7:0] b);
    cyc(0, 1, 1, 0, 1, b[7:4], 0);
    cyc(0, 1, 1, 0, 0, b[3:0], 0);
  endtask

  task automatic commit();
    set_addr(8'h01);
    wr_byte(8'h01);
    cyc(0, 1, 0, 0, 0, 4'h0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("voice_enable", 64'(voice_enable), 64'(e.en));
      chk("voice_octave", 64'(voice_octave), 64'(e.oct));
      chk("voice_pitch", 64'(voice_pitch), 64'(e.pit));
      chk("voice_volume", 64'(voice_volume), 64'(e.vol));
      chk("commit_pending", 64'(commit_pending), 64'(e.pend));
      chk("rd_nybble", 64'(rd_nybble), 64'(e.rd));
    end
  end

  bit       rr, re, rs, rad, rdh, rt;
  bit [3:0] rda;

  initial begin
    cyc(1, 0, 0, 0, 0, 4'h0, 0);
    cyc(1, 1, 1, 0, 0, 4'hF, 1);
    chk("reset_pitch", 64'(voice_pitch), 64'h0);
    chk("reset_pending", 64'(commit_pending), 64'h0);

    set_addr(8'h10);
    wr_byte(8'hA5);
    chk("shadow_only_pitch", 64'(voice_pitch), 64'h0);
    set_addr(8'h01);
    wr_byte(8'h01);
    chk("commit_armed", 64'(commit_pending), 64'h1);
    cyc(0, 1, 0, 0, 0, 4'h0, 1);
    chk("commit_pitch0", 64'(voice_pitch[7:0]), 64'hA5);
    chk("commit_cleared", 64'(commit_pending), 64'h0);

    set_addr(8'h00);
    wr_byte(8'h01);
    set_addr(8'h10);
    wr_byte(8'h11);
    wr_byte(8'h32);
    wr_byte(8'h0F);
    commit();
    chk("autoinc_pitch", 64'(voice_pitch[PW-1:0]), 64'h211);
    chk("autoinc_octave", 64'(voice_octave[2:0]), 64'h3);
    chk("autoinc_volume", 64'(voice_volume[3:0]), 64'hF);
    set_addr(8'h00);
    wr_byte(8'h00);

    set_addr(8'h10);
    wr_byte(8'h44);
    set_addr(8'h01);
    cyc(0, 1, 1, 0, 1, 4'h0, 0);
    cyc(0, 1, 1, 0, 0, 4'h1, 1);
    chk("coincide_nocopy", 64'(voice_pitch[7:0]), 64'h11);
    chk("coincide_pending", 64'(commit_pending), 64'h1);
    cyc(0, 1, 0, 0, 0, 4'h0, 1);
    chk("coincide_latecopy", 64'(voice_pitch[7:0]), 64'h44);

    set_addr(8'h20);
    wr_byte(8'hFF);
    set_addr(8'h04);
    wr_byte(8'hFF);
    commit();
    chk("unmapped_enable", 64'(voice_enable), 64'h0);
    set_addr(8'h00);
    wr_byte(8'h02);
    set_addr(8'h16);
    wr_byte(8'h07);
    chk("immediate_vol1", 64'(voice_volume[7:4]), 64'h7);
    set_addr(8'h00);
    wr_byte(8'h00);

    cyc(0, 0, 1, 1, 1, 4'h3, 1);
    cyc(0, 0, 1, 0, 0, 4'h9, 1);
    set_addr(8'h12);
    cyc(0, 1, 1, 0, 1, 4'hC, 0);
    cyc(1, 1, 0, 0, 0, 4'h0, 0);
    set_addr(8'h12);
    cyc(0, 1, 1, 0, 0, 4'h3, 0);
    commit();
    chk("reset_partial", 64'(voice_volume[3:0]), 64'h3);

    set_addr(8'h10);
    wr_byte(8'hA5);
    set_addr(8'h10);
    cyc(0, 1, 0, 0, 1, 4'h0, 0);
`ifdef PSG_READBACK_EN
    chk("readback_hi", 64'(rd_nybble), 64'hA);
`else
    chk("readback_off", 64'(rd_nybble), 64'h0);
`endif

    for (int n = 0; n < 2500; n++) begin
      rr  = ($urandom_range(0, 299) == 0);
      re  = ($urandom_range(0, 9) != 0);
      rs  = ($urandom_range(0, 3) != 0);
      rad = ($urandom_range(0, 2) == 0);
      rdh = 1'($urandom_range(0, 1));
      rda = (rad && rdh) ? 4'($urandom_range(0, 5)) : 4'($urandom);
      rt  = ($urandom_range(0, 6) == 0);
      cyc(rr, re, rs, rad, rdh, rda, rt);
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
